// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: start is sampled only in IDLE; busy is high for the WIDTH RUN
  // cycles; done pulses for one cycle when diff/bout (and ovf) are updated.
  logic [1:0]       state_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  logic             d_bit;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
    // New bits enter at the MSB so after WIDTH shifts bit 0 sits at index 0.
    res_next = {d_bit, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      br      <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            br      <= bin;
            cnt     <= '0;
            res_sh  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            diff    <= res_next;
            bout    <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            // d_bit is the result MSB on the final bit.
            ovf     <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations
// against an arithmetic reference, plus continuous-start and mid-run reset.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic [1:0]   state;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  // {ovf, bout, diff} expected per operation, pushed at capture
  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_diff;
  logic         last_bout;
  logic         last_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .state (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input int av, input int bv, input int bi);
    int raw, sa, sb, sr;
    logic [W-1:0] d;
    logic bo, ov;
    raw = av - bv - bi;
    d   = W'(raw & MASK);
    bo  = (raw < 0);
    sa  = (av >= (1 << (W-1))) ? av - (1 << W) : av;
    sb  = (bv >= (1 << (W-1))) ? bv - (1 << W) : bv;
    sr  = sa - sb - bi;
    ov  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return {ov, bo, d};
  endfunction

  task automatic check_outputs(input string tag, input logic [W+1:0] e);
    check({tag, "_diff"}, 32'(diff), 32'(e[W-1:0]));
    check({tag, "_bout"}, 32'(bout), 32'(e[W]));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
  endtask

  // driver: one full operation with operand/start noise during RUN and DONE
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    logic [W+1:0] e;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    exp_q.push_back(model(int'(av), int'(bv), int'(bi)));
    @(posedge clk); #1;
    for (int i = 0; i < W; i++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_diff_hold", 32'(diff), 32'(last_diff));
      check("run_bout_hold", 32'(bout), 32'(last_bout));
      start = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    e = exp_q.pop_front();
    check_outputs("op", e);
    last_diff = e[W-1:0]; last_bout = e[W]; last_ovf = e[W+1];
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_done", 32'(done), 32'd0);
    check("idle_state", 32'(state), 32'd0);
    check_outputs("hold", {last_ovf, last_bout, last_diff});
  endtask

  initial begin
    int done_cyc[$];
    logic [W+1:0] e;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check_outputs("rst", '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases, including borrow and overflow boundaries
    do_op(8'h5A, 8'h3C, 1'b0);
    do_op(8'h00, 8'h01, 1'b0);
    do_op(8'h10, 8'h0F, 1'b1);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1);
    do_op(8'h7F, 8'hFF, 1'b0);
    do_op(8'h00, 8'h00, 1'b0);

    // random operations
    for (int n = 0; n < 30; n++)
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    // start held high: operands are 5/3 whenever a capture can happen
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b1;
      if (state == 2'd0) begin
        a = 8'h05; b = 8'h03; bin = 1'b0;
      end else begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (done) begin
        done_cyc.push_back(i);
        check_outputs("cont", model(5, 3, 0));
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("cont_count", 32'(done_cyc.size()), 32'd2);
    if (done_cyc.size() >= 2) begin
      check("cont_first", 32'(done_cyc[0]), 32'd8);
      check("cont_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd10);
    end
    last_diff = 8'h02; last_bout = 1'b0; last_ovf = 1'b0;
    @(posedge clk); #1;
    check("cont_idle", 32'(state), 32'd0);

    // reset in the 4th RUN cycle aborts with no done pulse
    do_op(8'hC3, 8'h21, 1'b0);
    @(negedge clk);
    a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check_outputs("arst", '0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("arst_no_done", 32'(done), 32'd0);
      if (i == 2) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    do_op(8'h5A, 8'h3C, 1'b0);
    do_op(W'($urandom), W'($urandom), 1'b1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
